// File: rtl/raytracing_multitimer.sv
// Multi-channel Avalon-MM interval timer: NUM_CH prescaled down-counters with
// one-shot/continuous modes, snapshot capture and per-channel interrupts.
module raytracing_multitimer #(
    parameter int          NUM_CH       = 2,
    parameter int          CNT_W        = 64,
    parameter logic [63:0] RESET_PERIOD = 64'hFA56E9FF,
    parameter int          ADDR_W       = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    localparam logic [CNT_W-1:0] RST_CNT  = RESET_PERIOD[CNT_W-1:0];
    localparam logic             RST_ZERO = (RST_CNT == '0);

    // Bus handshake: a write takes effect on the rising edge where chipselect
    // is high and write_n is low; reads are unqualified and return the
    // addressed register one cycle after the address is presented.
    logic                    wr_en;
    logic [2:0]              reg_sel;
    logic [ADDR_W-1:0]       ch_sel;
    logic [NUM_CH-1:0][31:0] ch_rd;
    logic [31:0]             readdata_q, readdata_d;

    assign wr_en   = chipselect && !write_n;
    assign reg_sel = address[2:0];
    assign ch_sel  = address >> 3;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             ch_wr, wr_status, wr_ctrl, wr_period, wr_snap;
        logic             start, stop, tick, cnt_zero, to_event;
        logic [63:0]      period_wide, snap_wide;
        logic [31:0]      rd_word;
        logic [CNT_W-1:0] counter_q, counter_d, period_q, period_d, snap_q, snap_d;
        logic [7:0]       presc_q, presc_d, pcnt_q, pcnt_d;
        logic             ito_q, ito_d, cont_q, cont_d, to_q, to_d, run_q, run_d;
        logic             reload_q, reload_d, zero_dly_q, zero_dly_d;

        assign ch_wr       = wr_en && (ch_sel == ADDR_W'(g));
        assign wr_status   = ch_wr && (reg_sel == 3'd0);
        assign wr_ctrl     = ch_wr && (reg_sel == 3'd1);
        assign wr_period   = ch_wr && (reg_sel == 3'd2 || reg_sel == 3'd3);
        assign wr_snap     = ch_wr && (reg_sel == 3'd4 || reg_sel == 3'd5);
        assign start       = wr_ctrl && writedata[2];
        assign stop        = wr_ctrl && writedata[3];
        assign tick        = run_q && (pcnt_q == presc_q);
        assign cnt_zero    = (counter_q == '0);
        assign to_event    = cnt_zero && !zero_dly_q;
        assign period_wide = 64'(period_q);
        assign snap_wide   = 64'(snap_q);

        always_comb begin
            period_d   = period_q;
            counter_d  = counter_q;
            pcnt_d     = pcnt_q;
            run_d      = run_q;
            to_d       = to_q;
            snap_d     = snap_q;
            ito_d      = ito_q;
            cont_d     = cont_q;
            presc_d    = presc_q;
            reload_d   = wr_period;
            zero_dly_d = cnt_zero;

            if (ch_wr && reg_sel == 3'd2) period_d = CNT_W'({period_wide[63:32], writedata});
            if (ch_wr && reg_sel == 3'd3) period_d = CNT_W'({writedata, period_wide[31:0]});

            // One-shot holds at zero; continuous reloads on the next tick.
            if (reload_q) begin
                counter_d = period_q;
            end else if (tick) begin
                if (!cnt_zero)   counter_d = counter_q - CNT_W'(1);
                else if (cont_q) counter_d = period_q;
            end

            if (start || reload_q) pcnt_d = '0;
            else if (run_q)        pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;

            if (start)                      run_d = 1'b1;
            else if (stop)                  run_d = 1'b0;
            else if (reload_q)              run_d = 1'b0;
            else if (cnt_zero && !cont_q)   run_d = 1'b0;

            if (wr_status)     to_d = 1'b0;
            else if (to_event) to_d = 1'b1;

            if (wr_snap) snap_d = counter_q;

            if (wr_ctrl) begin
                ito_d   = writedata[0];
                cont_d  = writedata[1];
                presc_d = writedata[15:8];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                counter_q  <= RST_CNT;
                period_q   <= RST_CNT;
                snap_q     <= '0;
                presc_q    <= '0;
                pcnt_q     <= '0;
                ito_q      <= 1'b0;
                cont_q     <= 1'b0;
                to_q       <= 1'b0;
                run_q      <= 1'b0;
                reload_q   <= 1'b0;
                zero_dly_q <= RST_ZERO;
            end else begin
                counter_q  <= counter_d;
                period_q   <= period_d;
                snap_q     <= snap_d;
                presc_q    <= presc_d;
                pcnt_q     <= pcnt_d;
                ito_q      <= ito_d;
                cont_q     <= cont_d;
                to_q       <= to_d;
                run_q      <= run_d;
                reload_q   <= reload_d;
                zero_dly_q <= zero_dly_d;
            end
        end

        always_comb begin
            rd_word = '0;
            case (reg_sel)
                3'd0:    rd_word = {30'd0, run_q, to_q};
                3'd1:    rd_word = {16'd0, presc_q, 6'd0, cont_q, ito_q};
                3'd2:    rd_word = period_wide[31:0];
                3'd3:    rd_word = period_wide[63:32];
                3'd4:    rd_word = snap_wide[31:0];
                3'd5:    rd_word = snap_wide[63:32];
                default: rd_word = '0;
            endcase
        end

        assign ch_rd[g]   = rd_word;
        assign irq_vec[g] = to_q && ito_q;
    end

    // Unpopulated channel indices fall through to zero.
    always_comb begin
        readdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == ADDR_W'(i)) readdata_d = ch_rd[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata_q <= '0;
        else          readdata_q <= readdata_d;
    end

    assign readdata = readdata_q;
    assign irq      = |irq_vec;

endmodule

// File: tb/tb_raytracing_multitimer.sv
// Self-checking bench for raytracing_multitimer: directed scenarios plus a
// randomized bus phase, all checked against a cycle-level behavioural model.
module tb_raytracing_multitimer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;
    logic [1:0]  irq_vec;

    raytracing_multitimer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      cycle_no = 0;
    logic [31:0] exp_rd;

    // Behavioural model of both channels, one entry per channel.
    logic [63:0] m_cnt[2], m_per[2], m_snap[2];
    int          m_pc[2], m_presc[2];
    bit          m_ito[2], m_cont[2], m_to[2], m_run[2], m_rel[2], m_zp[2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c] = 64'hFA56E9FF; m_per[c] = 64'hFA56E9FF; m_snap[c] = '0;
            m_pc[c] = 0; m_presc[c] = 0; m_ito[c] = 0; m_cont[c] = 0;
            m_to[c] = 0; m_run[c] = 0; m_rel[c] = 0; m_zp[c] = 0;
        end
    endtask

    function automatic logic [31:0] mread(input logic [3:0] a);
        int c;
        c = int'(a[3]);
        case (a[2:0])
            3'd0:    return {30'd0, m_run[c], m_to[c]};
            3'd1:    return {16'd0, 8'(m_presc[c]), 6'd0, m_cont[c], m_ito[c]};
            3'd2:    return m_per[c][31:0];
            3'd3:    return m_per[c][63:32];
            3'd4:    return m_snap[c][31:0];
            3'd5:    return m_snap[c][63:32];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [1:0] m_irq_vec();
        return {m_to[1] && m_ito[1], m_to[0] && m_ito[0]};
    endfunction

    task automatic model_step(input bit cs, input bit wn, input logic [3:0] a, input logic [31:0] d);
        for (int c = 0; c < 2; c++) begin
            bit sel, zero, tick, start, stop, old_run, old_rel;
            int r;
            sel     = cs && !wn && (int'(a[3]) == c);
            r       = int'(a[2:0]);
            zero    = (m_cnt[c] == 64'd0);
            tick    = m_run[c] && (m_pc[c] == m_presc[c]);
            start   = sel && r == 1 && d[2];
            stop    = sel && r == 1 && d[3];
            old_run = m_run[c];
            old_rel = m_rel[c];
            if (sel && (r == 4 || r == 5)) m_snap[c] = m_cnt[c];
            if (old_rel) m_cnt[c] = m_per[c];
            else if (tick && !zero) m_cnt[c] = m_cnt[c] - 64'd1;
            else if (tick && zero && m_cont[c]) m_cnt[c] = m_per[c];
            if (start || old_rel) m_pc[c] = 0;
            else if (old_run) m_pc[c] = tick ? 0 : m_pc[c] + 1;
            if (start) m_run[c] = 1;
            else if (stop || old_rel || (zero && !m_cont[c])) m_run[c] = 0;
            if (sel && r == 0) m_to[c] = 0;
            else if (zero && !m_zp[c]) m_to[c] = 1;
            m_zp[c]  = zero;
            m_rel[c] = sel && (r == 2 || r == 3);
            if (sel && r == 2) m_per[c][31:0] = d;
            if (sel && r == 3) m_per[c][63:32] = d;
            if (sel && r == 1) begin
                m_ito[c] = d[0]; m_cont[c] = d[1]; m_presc[c] = int'(d[15:8]);
            end
        end
    endtask

    task automatic step(input bit cs, input bit wn, input logic [3:0] a, input logic [31:0] d);
        chipselect = cs; write_n = wn; address = a; writedata = d;
        exp_rd = mread(a);
        @(posedge clk);
        model_step(cs, wn, a, d);
        cycle_no++;
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b1, 1'b1, a, 32'd0);
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_readdata: got %h want 0", readdata); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_cmp++; if (irq_vec !== 2'b00) begin n_bad++; $display("FAIL reset_irq_vec: got %b want 00", irq_vec); end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        address = 4'd2;
        #2;
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL read_latency: got %h want 0", readdata); end
        rd(4'd2);
        n_cmp++; if (readdata !== 32'hFA56E9FF) begin n_bad++; $display("FAIL reset_period_l: got %h want fa56e9ff", readdata); end
        rd(4'd3);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_period_h: got %h want 0", readdata); end
        rd(4'd0);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_status: got %h want 0", readdata); end
        rd(4'd9);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_control1: got %h want 0", readdata); end
    endtask

    task automatic test_oneshot();
        int k;
        k = 0;
        wr(4'd2, 32'd5);
        wr(4'd3, 32'd0);
        wr(4'd1, 32'h0000_0005);
        while (irq !== 1'b1 && k < 40) begin rd(4'd0); k++; end
        n_cmp++; if (k != 6) begin n_bad++; $display("FAIL oneshot_cycles_to_irq: got %0d want 6", k); end
        n_cmp++; if (irq_vec !== 2'b01) begin n_bad++; $display("FAIL oneshot_irq_vec: got %b want 01", irq_vec); end
        rd(4'd0);
        n_cmp++; if (readdata !== 32'h1) begin n_bad++; $display("FAIL oneshot_status: got %h want 1", readdata); end
        wr(4'd4, 32'd0);
        rd(4'd4);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL oneshot_hold_zero: got %h want 0", readdata); end
        wr(4'd0, 32'd0);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL oneshot_irq_clear: got %b want 0", irq); end
        n_cmp++; if (irq_vec !== m_irq_vec()) begin n_bad++; $display("FAIL oneshot_model_irq: got %b want %b", irq_vec, m_irq_vec()); end
    endtask

    task automatic test_continuous();
        int     k;
        longint c1, c2;
        k = 0;
        wr(4'd10, 32'd2);
        wr(4'd11, 32'd0);
        wr(4'd9, 32'h0000_0307);
        while (irq !== 1'b1 && k < 40) begin rd(4'd8); k++; end
        c1 = cycle_no;
        n_cmp++; if (k != 9) begin n_bad++; $display("FAIL cont_first_event: got %0d want 9", k); end
        n_cmp++; if (irq_vec !== 2'b10) begin n_bad++; $display("FAIL cont_irq_vec: got %b want 10", irq_vec); end
        wr(4'd8, 32'd0);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL cont_clear: got %b want 0", irq); end
        k = 0;
        while (irq !== 1'b1 && k < 40) begin rd(4'd8); k++; end
        c2 = cycle_no;
        n_cmp++; if (c2 - c1 != 64'd12) begin n_bad++; $display("FAIL cont_period_cycles: got %0d want 12", c2 - c1); end
        rd(4'd8);
        n_cmp++; if (readdata !== 32'h3) begin n_bad++; $display("FAIL cont_status: got %h want 3", readdata); end
        wr(4'd9, 32'h0000_030B);
        wr(4'd8, 32'd0);
        rd(4'd8);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL cont_stopped: got %h want 0", readdata); end
    endtask

    task automatic test_snapshot();
        longint      c_ctrl, k;
        logic [63:0] e;
        int          n;
        wr(4'd3, 32'd1);
        wr(4'd2, 32'd0);
        wr(4'd1, 32'h0000_0004);
        c_ctrl = cycle_no;
        wr(4'd4, 32'd0);
        rd(4'd4);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL snap0_l: got %h want 0", readdata); end
        rd(4'd5);
        n_cmp++; if (readdata !== 32'd1) begin n_bad++; $display("FAIL snap0_h: got %h want 1", readdata); end
        n = $urandom_range(2, 30);
        repeat (n) rd(4'd5);
        rd(4'd4);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL snap_frozen: got %h want 0", readdata); end
        wr(4'd5, 32'd0);
        k = cycle_no - c_ctrl;
        e = 64'h1_0000_0000 - 64'(k - 1);
        rd(4'd4);
        n_cmp++; if (readdata !== e[31:0]) begin n_bad++; $display("FAIL snap1_l: got %h want %h", readdata, e[31:0]); end
        rd(4'd5);
        n_cmp++; if (readdata !== e[63:32]) begin n_bad++; $display("FAIL snap1_h: got %h want %h", readdata, e[63:32]); end
        wr(4'd1, 32'h0000_0008);
    endtask

    task automatic test_simultaneous();
        wr(4'd9, 32'h0000_000E);
        rd(4'd8);
        n_cmp++; if (readdata[1] !== 1'b1) begin n_bad++; $display("FAIL start_stop_run: got %b want 1", readdata[1]); end
        wr(4'd10, 32'h77);
        rd(4'd8);
        rd(4'd8);
        n_cmp++; if (readdata[1] !== 1'b0) begin n_bad++; $display("FAIL period_write_run: got %b want 0", readdata[1]); end
        wr(4'd12, 32'd0);
        rd(4'd12);
        n_cmp++; if (readdata !== 32'h77) begin n_bad++; $display("FAIL period_write_counter: got %h want 77", readdata); end
        wr(4'd0, 32'd0);
        wr(4'd2, 32'd3);
        wr(4'd3, 32'd0);
        wr(4'd1, 32'h0000_0005);
        repeat (3) rd(4'd0);
        wr(4'd0, 32'd0);
        rd(4'd0);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL status_wins_status: got %h want 0", readdata); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL status_wins_irq: got %b want 0", irq); end
        repeat (5) rd(4'd0);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL no_repeat_event: got %b want 0", irq); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [3:0]  a;
            logic [31:0] d;
            a = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) begin
                case (a[2:0])
                    3'd1:    d = {16'd0, 8'($urandom_range(0, 3)), 4'd0, 4'($urandom_range(0, 15))};
                    3'd2:    d = 32'($urandom_range(0, 12));
                    3'd3:    d = 32'd0;
                    default: d = $urandom;
                endcase
                wr(a, d);
            end else begin
                rd(a);
            end
            n_cmp++; if (readdata !== exp_rd) begin n_bad++; $display("FAIL rand_readdata addr %h: got %h want %h", a, readdata, exp_rd); end
            n_cmp++; if (irq_vec !== m_irq_vec()) begin n_bad++; $display("FAIL rand_irq_vec: got %b want %b", irq_vec, m_irq_vec()); end
            n_cmp++; if (irq !== |m_irq_vec()) begin n_bad++; $display("FAIL rand_irq: got %b want %b", irq, |m_irq_vec()); end
        end
    endtask

    task automatic test_reset_mid();
        wr(4'd11, 32'd0);
        wr(4'd10, 32'h40);
        wr(4'd9, 32'h0000_0705);
        rd(4'd10);
        rd(4'd10);
        n_cmp++; if (readdata !== 32'h40) begin n_bad++; $display("FAIL mid_pre_reset: got %h want 40", readdata); end
        #3 reset_n = 1'b0;
        #1;
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL mid_reset_readdata: got %h want 0", readdata); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
        n_cmp++; if (irq_vec !== 2'b00) begin n_bad++; $display("FAIL mid_reset_irq_vec: got %b want 00", irq_vec); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
        rd(4'd9);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL mid_control: got %h want 0", readdata); end
        rd(4'd10);
        n_cmp++; if (readdata !== 32'hFA56E9FF) begin n_bad++; $display("FAIL mid_period: got %h want fa56e9ff", readdata); end
        wr(4'd12, 32'd0);
        rd(4'd12);
        n_cmp++; if (readdata !== 32'hFA56E9FF) begin n_bad++; $display("FAIL mid_counter_l: got %h want fa56e9ff", readdata); end
        rd(4'd13);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL mid_counter_h: got %h want 0", readdata); end
        rd(4'd8);
        n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL mid_status: got %h want 0", readdata); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_oneshot();
        test_continuous();
        test_snapshot();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
